// File: rtl/vga_pkg.sv
// Shared constants and types for the text-mode VGA controller.
package vga_pkg;

    localparam int unsigned N_COL           = 175;
    localparam int unsigned N_ROW           = 65;
    localparam int unsigned N_COL_WIDTH     = 8;
    localparam int unsigned N_ROW_WIDTH     = 7;
    localparam int unsigned N_CHARS_WIDTH   = 7;
    localparam int unsigned UART_DATA_WIDTH = 8;

    localparam logic [6:0] CHAR_SPACE = 7'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CMD_CLEAR  = 8'hFF;

    typedef enum logic [2:0] {
        S_COL,
        S_ROW,
        S_CHR,
        S_END,
        S_SYNC,
        S_CLR
    } state_e;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// UART byte input and screen-buffer write bus of the command decoder.
interface uart_cmd_decoder_if;
    import vga_pkg::*;

    logic                       wr_i;
    logic [UART_DATA_WIDTH-1:0] data_i;
    logic                       wr_en_o;
    logic [N_COL_WIDTH-1:0]     col_w_o;
    logic [N_ROW_WIDTH-1:0]     row_w_o;
    logic [N_CHARS_WIDTH-1:0]   din_o;
    logic                       busy_o;
    logic                       err_o;

    modport master (
        output wr_i, data_i,
        input  wr_en_o, col_w_o, row_w_o, din_o, busy_o, err_o
    );

    modport slave (
        input  wr_i, data_i,
        output wr_en_o, col_w_o, row_w_o, din_o, busy_o, err_o
    );

endinterface

// File: rtl/uart_cmd_decoder_rise_detect.sv
// Rising-edge detector: one-cycle flag when sig_i is high now and was low last cycle.
module rise_detect (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic sig_i,
    output logic rise_c_o
);

    logic sig_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) sig_q <= 1'b0;
        else         sig_q <= sig_i;
    end

    assign rise_c_o = sig_i & ~sig_q;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Turns column/row/char/LF byte packets into buffer writes; 0xFF,LF sweeps the screen with spaces.
module uart_cmd_decoder
    import vga_pkg::*;
#(
    parameter int unsigned N_COL           = vga_pkg::N_COL,
    parameter int unsigned N_ROW           = vga_pkg::N_ROW,
    parameter int unsigned N_COL_WIDTH     = vga_pkg::N_COL_WIDTH,
    parameter int unsigned N_ROW_WIDTH     = vga_pkg::N_ROW_WIDTH,
    parameter int unsigned N_CHARS_WIDTH   = vga_pkg::N_CHARS_WIDTH,
    parameter int unsigned UART_DATA_WIDTH = vga_pkg::UART_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    uart_cmd_decoder_if.slave   bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0]           TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [UART_DATA_WIDTH-1:0] COL_LIM  = UART_DATA_WIDTH'(N_COL);
    localparam logic [UART_DATA_WIDTH-1:0] ROW_LIM  = UART_DATA_WIDTH'(N_ROW);
    localparam logic [N_COL_WIDTH-1:0]     COL_LAST = N_COL_WIDTH'(N_COL - 1);
    localparam logic [N_ROW_WIDTH-1:0]     ROW_LAST = N_ROW_WIDTH'(N_ROW - 1);

    state_e                     state_q;
    logic                       byte_ev_c;
    logic                       tmo_hit_c;
    logic [UART_DATA_WIDTH-1:0] data_c;
    logic [N_COL_WIDTH-1:0]     col_q, swp_col_q, col_w_q;
    logic [N_ROW_WIDTH-1:0]     row_q, swp_row_q, row_w_q;
    logic [N_CHARS_WIDTH-1:0]   chr_q, din_q;
    logic                       clr_q, bad_q;
    logic                       wr_en_q, busy_q, err_q;
    logic [TMO_W-1:0]           tmo_q;

    rise_detect u_rise (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .sig_i    (bus.wr_i),
        .rise_c_o (byte_ev_c)
    );

    assign data_c    = bus.data_i;
    // A byte arriving in the expiry cycle takes precedence over the timeout.
    assign tmo_hit_c = !byte_ev_c && (tmo_q == TMO_LAST);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= S_COL;
            col_q     <= '0;
            row_q     <= '0;
            chr_q     <= '0;
            clr_q     <= 1'b0;
            bad_q     <= 1'b0;
            tmo_q     <= '0;
            swp_col_q <= '0;
            swp_row_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            col_w_q   <= '0;
            row_w_q   <= '0;
            din_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;

            if (byte_ev_c || tmo_hit_c || state_q == S_COL || state_q == S_CLR)
                tmo_q <= '0;
            else
                tmo_q <= tmo_q + TMO_W'(1);

            case (state_q)
                S_COL: begin
                    clr_q <= 1'b0;
                    bad_q <= 1'b0;
                    if (byte_ev_c) begin
                        if (data_c == CMD_CLEAR) begin
                            clr_q   <= 1'b1;
                            state_q <= S_END;
                        end else begin
                            col_q   <= (data_c >= COL_LIM) ? N_COL_WIDTH'(data_c - COL_LIM)
                                                           : N_COL_WIDTH'(data_c);
                            state_q <= S_ROW;
                        end
                    end
                end
                S_ROW: begin
                    if (byte_ev_c) begin
                        row_q <= data_c[N_ROW_WIDTH-1:0];
                        if (data_c >= ROW_LIM) bad_q <= 1'b1;
                        state_q <= S_CHR;
                    end else if (tmo_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= S_COL;
                    end
                end
                S_CHR: begin
                    if (byte_ev_c) begin
                        chr_q <= data_c[N_CHARS_WIDTH-1:0];
                        if (data_c[7]) bad_q <= 1'b1;
                        state_q <= S_END;
                    end else if (tmo_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= S_COL;
                    end
                end
                S_END: begin
                    if (byte_ev_c) begin
                        if (data_c != CHAR_LF) begin
                            err_q   <= 1'b1;
                            state_q <= S_SYNC;
                        end else if (clr_q) begin
                            swp_col_q <= '0;
                            swp_row_q <= '0;
                            state_q   <= S_CLR;
                        end else if (bad_q) begin
                            err_q   <= 1'b1;
                            state_q <= S_COL;
                        end else begin
                            wr_en_q <= 1'b1;
                            col_w_q <= col_q;
                            row_w_q <= row_q;
                            din_q   <= chr_q;
                            state_q <= S_COL;
                        end
                    end else if (tmo_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= S_COL;
                    end
                end
                S_SYNC: begin
                    if (byte_ev_c) begin
                        if (data_c == CHAR_LF) state_q <= S_COL;
                    end else if (tmo_hit_c) begin
                        err_q   <= 1'b1;
                        state_q <= S_COL;
                    end
                end
                S_CLR: begin
                    // Row-major sweep; incoming bytes are dropped but flagged.
                    wr_en_q <= 1'b1;
                    busy_q  <= 1'b1;
                    col_w_q <= swp_col_q;
                    row_w_q <= swp_row_q;
                    din_q   <= N_CHARS_WIDTH'(CHAR_SPACE);
                    err_q   <= byte_ev_c;
                    if (swp_col_q == COL_LAST) begin
                        swp_col_q <= '0;
                        if (swp_row_q == ROW_LAST) begin
                            swp_row_q <= '0;
                            state_q   <= S_COL;
                        end else begin
                            swp_row_q <= swp_row_q + N_ROW_WIDTH'(1);
                        end
                    end else begin
                        swp_col_q <= swp_col_q + N_COL_WIDTH'(1);
                    end
                end
                default: state_q <= S_COL;
            endcase
        end
    end

    assign bus.wr_en_o = wr_en_q;
    assign bus.col_w_o = col_w_q;
    assign bus.row_w_o = row_w_q;
    assign bus.din_o   = din_q;
    assign bus.busy_o  = busy_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: directed table, random packets vs packet model, sweep/timeout/reset cases.
module tb_uart_cmd_decoder;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_cmd_decoder_if bus ();

    uart_cmd_decoder #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        logic       we, er;
        logic [7:0] col;
        logic [6:0] row, din;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns outputs one cycle after the byte event and whether anything lingered a cycle later.
    task automatic send_byte(input logic [7:0] b, output logic we, output logic er,
                             output logic [21:0] cw, output logic tail);
        bus.data_i = b;
        bus.wr_i   = 1'b1;
        @(negedge clk);
        we = bus.wr_en_o;
        er = bus.err_o;
        cw = {bus.col_w_o, bus.row_w_o, bus.din_o};
        bus.wr_i = 1'b0;
        @(negedge clk);
        tail = bus.wr_en_o | bus.err_o;
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                               input logic [7:0] b3, output logic we, output logic er,
                               output logic [21:0] cw, output logic noise);
        logic w, e, t;
        logic [21:0] c;
        send_byte(b0, w, e, c, t); noise = w | e | t;
        send_byte(b1, w, e, c, t); noise |= w | e | t;
        send_byte(b2, w, e, c, t); noise |= w | e | t;
        send_byte(b3, we, er, cw, t); noise |= t;
    endtask

    // Packet-level model: {we, er, col, row, din}.
    function automatic logic [23:0] model_pkt(input logic [7:0] c, input logic [7:0] r,
                                              input logic [7:0] ch, input logic [7:0] t);
        int col;
        logic we, er;
        col = (c >= 175) ? int'(c) - 175 : int'(c);
        we = 1'b0;
        er = 1'b0;
        if (t != 8'h0A)                er = 1'b1;
        else if (r >= 65 || ch >= 128) er = 1'b1;
        else                           we = 1'b1;
        return {we, er, 8'(col), r[6:0], ch[6:0]};
    endfunction

    task automatic check_outputs_zero(input string name);
        check(name, 32'({bus.wr_en_o, bus.busy_o, bus.err_o, bus.col_w_o, bus.row_w_o, bus.din_o}), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        logic we, er, nz, t;
        logic [21:0] cw;
        logic [23:0] m;

        vecs[0] = '{8'h05, 8'h03, 8'h41, 8'h0A, 1'b1, 1'b0, 8'd5,   7'd3,  7'h41};
        vecs[1] = '{8'hB4, 8'h00, 8'h42, 8'h0A, 1'b1, 1'b0, 8'd5,   7'd0,  7'h42};
        vecs[2] = '{8'h01, 8'h41, 8'h43, 8'h0A, 1'b0, 1'b1, 8'd0,   7'd0,  7'h00};
        vecs[3] = '{8'h01, 8'h40, 8'h43, 8'h0A, 1'b1, 1'b0, 8'd1,   7'd64, 7'h43};
        vecs[4] = '{8'hAE, 8'h02, 8'h7F, 8'h0A, 1'b1, 1'b0, 8'd174, 7'd2,  7'h7F};
        vecs[5] = '{8'hAF, 8'h00, 8'h20, 8'h0A, 1'b1, 1'b0, 8'd0,   7'd0,  7'h20};
        vecs[6] = '{8'hFE, 8'h3F, 8'h00, 8'h0A, 1'b1, 1'b0, 8'd79,  7'd63, 7'h00};
        vecs[7] = '{8'h02, 8'h02, 8'h80, 8'h0A, 1'b0, 1'b1, 8'd0,   7'd0,  7'h00};

        bus.wr_i   = 1'b0;
        bus.data_i = 8'h00;
        #12;
        check_outputs_zero("reset_outputs");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_outputs_zero("post_reset_idle");

        // Directed table
        for (int i = 0; i < 8; i++) begin
            send_packet(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3, we, er, cw, nz);
            check($sformatf("vec%0d_we", i), 32'(we), 32'(vecs[i].we));
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].er));
            check($sformatf("vec%0d_quiet", i), 32'(nz), 32'd0);
            if (vecs[i].we)
                check($sformatf("vec%0d_data", i), 32'(cw), 32'({vecs[i].col, vecs[i].row, vecs[i].din}));
        end

        // Bad terminator, resync on LF, then normal packet
        send_packet(8'h01, 8'h02, 8'h43, 8'h58, we, er, cw, nz);
        check("sync_term_err", 32'({we, er, nz}), 32'b010);
        send_byte(8'h11, we, er, cw, t);
        check("sync_discard", 32'({we, er, t}), 32'd0);
        send_byte(8'h0A, we, er, cw, t);
        check("sync_lf_quiet", 32'({we, er, t}), 32'd0);
        send_packet(8'h05, 8'h06, 8'h07, 8'h0A, we, er, cw, nz);
        check("sync_after_write", 32'({we, er, nz}), 32'b100);
        check("sync_after_data", 32'(cw), 32'({8'd5, 7'd6, 7'h07}));

        // Random packets against the packet model
        for (int i = 0; i < 60; i++) begin
            logic [7:0] c, r, ch, tm, g;
            c  = 8'($urandom_range(0, 254));
            r  = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 64)) : 8'($urandom_range(0, 255));
            ch = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, 127)) : 8'($urandom_range(0, 255));
            tm = 8'h0A;
            if ($urandom_range(0, 4) == 0) begin
                tm = 8'($urandom_range(0, 255));
                if (tm == 8'h0A) tm = 8'h0B;
            end
            m = model_pkt(c, r, ch, tm);
            send_packet(c, r, ch, tm, we, er, cw, nz);
            check($sformatf("rnd%0d_we", i), 32'(we), 32'(m[23]));
            check($sformatf("rnd%0d_err", i), 32'(er), 32'(m[22]));
            check($sformatf("rnd%0d_quiet", i), 32'(nz), 32'd0);
            if (m[23]) check($sformatf("rnd%0d_data", i), 32'(cw), 32'(m[21:0]));
            if (tm != 8'h0A) begin
                logic junk;
                junk = 1'b0;
                for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
                    g = 8'($urandom_range(0, 255));
                    if (g == 8'h0A) g = 8'h0C;
                    send_byte(g, we, er, cw, t);
                    junk |= we | er | t;
                end
                send_byte(8'h0A, we, er, cw, t);
                junk |= we | er | t;
                check($sformatf("rnd%0d_resync", i), 32'(junk), 32'd0);
            end
        end

        // Clear sweep with a byte injected midway
        begin
            int first_we, last_we, n_we, bad_coord, busy_mis, err_n, err_at;
            logic [21:0] last_cw;
            first_we = 0; last_we = 0; n_we = 0; bad_coord = 0; busy_mis = 0; err_n = 0; err_at = 0;
            last_cw = '0;
            send_byte(8'hFF, we, er, cw, t);
            check("clr_cmd_quiet", 32'({we, er, t}), 32'd0);
            bus.data_i = 8'h0A;
            bus.wr_i   = 1'b1;
            for (int n = 1; n <= 11500; n++) begin
                @(negedge clk);
                if (bus.wr_en_o) begin
                    if (first_we == 0) first_we = n;
                    last_we = n;
                    last_cw = {bus.col_w_o, bus.row_w_o, bus.din_o};
                    if (last_cw !== {8'(n_we % 175), 7'(n_we / 175), 7'h20}) bad_coord++;
                    n_we++;
                end
                if (bus.busy_o !== bus.wr_en_o) busy_mis++;
                if (bus.err_o) begin err_n++; err_at = n; end
                if (n == 1) bus.wr_i = 1'b0;
                if (n == 5000) begin bus.data_i = 8'h33; bus.wr_i = 1'b1; end
                if (n == 5001) bus.wr_i = 1'b0;
            end
            check("clr_first_cycle", 32'(first_we), 32'd2);
            check("clr_write_count", 32'(n_we), 32'd11375);
            check("clr_last_cycle", 32'(last_we), 32'd11376);
            check("clr_coord_errs", 32'(bad_coord), 32'd0);
            check("clr_last_cell", 32'(last_cw), 32'({8'd174, 7'd64, 7'h20}));
            check("clr_busy_mismatch", 32'(busy_mis), 32'd0);
            check("clr_err_count", 32'(err_n), 32'd1);
            check("clr_err_cycle", 32'(err_at), 32'd5001);
        end

        // Timeout after a partial packet
        begin
            int first_err, err_n;
            first_err = 0; err_n = 0;
            send_byte(8'h07, we, er, cw, t);
            send_byte(8'h02, we, er, cw, t);
            for (int n = 3; n <= 150; n++) begin
                @(negedge clk);
                if (bus.err_o) begin
                    err_n++;
                    if (first_err == 0) first_err = n;
                end
            end
            check("tmo_err_cycle", 32'(first_err), 32'd101);
            check("tmo_err_count", 32'(err_n), 32'd1);
            send_packet(8'h01, 8'h01, 8'h44, 8'h0A, we, er, cw, nz);
            check("tmo_recover_we", 32'({we, er, nz}), 32'b100);
            check("tmo_recover_data", 32'(cw), 32'({8'd1, 7'd1, 7'h44}));
        end

        // Reset during a clear sweep
        begin
            int resid;
            resid = 0;
            send_byte(8'hFF, we, er, cw, t);
            bus.data_i = 8'h0A;
            bus.wr_i   = 1'b1;
            @(negedge clk);
            bus.wr_i = 1'b0;
            repeat (50) @(negedge clk);
            check("rst_sweep_busy", 32'(bus.busy_o), 32'd1);
            rstn = 1'b0;
            #1;
            check_outputs_zero("rst_sweep_outputs");
            @(negedge clk);
            @(negedge clk);
            rstn = 1'b1;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                resid += int'(bus.wr_en_o | bus.busy_o | bus.err_o);
            end
            check("rst_sweep_residual", 32'(resid), 32'd0);
            send_packet(8'h09, 8'h08, 8'h4B, 8'h0A, we, er, cw, nz);
            check("rst_sweep_fresh", 32'({we, er, nz}), 32'b100);
            check("rst_sweep_fresh_data", 32'(cw), 32'({8'd9, 7'd8, 7'h4B}));
        end

        // Reset while waiting for the char byte
        send_byte(8'h08, we, er, cw, t);
        send_byte(8'h09, we, er, cw, t);
        rstn = 1'b0;
        #1;
        check_outputs_zero("rst_chr_outputs");
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        send_packet(8'h03, 8'h04, 8'h45, 8'h0A, we, er, cw, nz);
        check("rst_chr_fresh", 32'({we, er, nz}), 32'b100);
        check("rst_chr_fresh_data", 32'(cw), 32'({8'd3, 7'd4, 7'h45}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Parses the UART byte stream into screen-buffer write commands for the text-mode VGA controller. Sits between the `uart` receiver and the `buffer` write port, in the 122.61 MHz pixel clock domain. It enforces the packet format column → row → char → LF, rejects malformed packets, resynchronises on LF and recovers after a timeout. It also implements a clear-screen command that fills every cell with a space.

## Interface
Parameters:
- `N_COL`, 175, number of text columns
- `N_ROW`, 65, number of text rows
- `N_COL_WIDTH`, 8, column index width
- `N_ROW_WIDTH`, 7, row index width
- `N_CHARS_WIDTH`, 7, character code width
- `UART_DATA_WIDTH`, 8, received byte width
- `TIMEOUT_CYCLES`, 1000000, idle cycles before a partial packet is abandoned

Ports:
- `clk_i` in 1, pixel clock. One clock domain only.
- `rstn_i` in 1, reset. Asynchronous, active-low.
- `wr_i` in 1, UART data-valid level. Its rising edge marks a new byte.
- `data_i` in UART_DATA_WIDTH, received byte. Stable while `wr_i` is high.
- `wr_en_o` out 1, single-cycle write strobe to the buffer.
- `col_w_o` out N_COL_WIDTH, write column.
- `row_w_o` out N_ROW_WIDTH, write row.
- `din_o` out N_CHARS_WIDTH, ASCII code to write.
- `busy_o` out 1, high while a clear sweep runs.
- `err_o` out 1, single-cycle pulse for each rejected packet, dropped byte or timeout.

## Operation
- Byte event: `wr_i`==1 at a posedge and `wr_i`==0 at the previous posedge. The delay register resets to 0.
- States:
  - `S_COL`, the reset state.
  - `S_ROW`, `S_CHR`, `S_END`.
  - `S_SYNC`.
  - `S_CLR`.
- `S_COL` on a byte event:
  - Byte 0xFF: set the clear flag and go to `S_END`.
  - Byte ≥ N_COL: latch col = byte − N_COL (8-bit), go to `S_ROW`.
  - Otherwise: latch col = byte, go to `S_ROW`.
- `S_ROW`: latch row = byte[N_ROW_WIDTH-1:0]. If byte ≥ N_ROW, set the bad flag. Go to `S_CHR`.
- `S_CHR`: latch din = byte[6:0]. If byte[7]=1, set the bad flag. Go to `S_END`.
- `S_END`, byte 0x0A:
  - Clear flag set: go to `S_CLR`.
  - Else bad flag set: pulse `err_o`, go to `S_COL`.
  - Otherwise: pulse `wr_en_o` with the latched col/row/din, go to `S_COL`.
- `S_END`, byte ≠ 0x0A: pulse `err_o`, go to `S_SYNC`.
- `S_SYNC`: discard bytes until 0x0A, then go to `S_COL`. Emit no further `err_o` while in this state.
- `S_CLR`:
  - Sweep row-major from (0,0) to (N_COL−1, N_ROW−1), one write per cycle with din=0x20.
  - `busy_o`=1 throughout.
  - After the last cell, go to `S_COL`.
  - Each byte event in this state is dropped with an `err_o` pulse.
- Flags (clear, bad) are cleared on entry to `S_COL`.
- Timeout counter:
  - Runs in `S_ROW`, `S_CHR`, `S_END` and `S_SYNC`. Resets on every byte event and in `S_COL`/`S_CLR`.
  - Reaching TIMEOUT_CYCLES−1: pulse `err_o` and go to `S_COL`.
  - A byte event in the expiry cycle wins: the byte is processed and the counter resets.

## Timing
- Reset values:
  - `wr_en_o`=0, `busy_o`=0, `err_o`=0.
  - `col_w_o`=0, `row_w_o`=0, `din_o`=0.
  - State `S_COL`, counters 0.
- All outputs are registered.
- `wr_en_o` and `err_o` rise on the posedge that samples the LF byte event, with latency 1 cycle after `wr_i` is seen high. Each is high for exactly 1 cycle.
- `col_w_o`, `row_w_o` and `din_o` are valid in every cycle `wr_en_o`=1.
- Clear sweep:
  - First write is on the posedge after the LF byte event.
  - Exactly N_COL×N_ROW = 11375 consecutive `wr_en_o` cycles.
  - `busy_o` is high for exactly those cycles.
- Column counter wraps N_COL−1→0 and increments the row. The sweep ends when the row counter reaches N_ROW−1 and the column counter reaches N_COL−1.
- Reset asserted mid-packet or mid-sweep aborts immediately. No residual write follows reset release.

## Structure
- Shared package `vga_pkg` holds:
  - N_COL, N_ROW and the width constants.
  - CHAR_SPACE=7'h20, CHAR_LF=8'h0A, CMD_CLEAR=8'hFF.
  - The state enum.
- One sub-module, `rise_detect`: a registered edge detector with an async active-low reset, also reusable for other strobes.
- The top-level `top` replaces its inline UART parsing with this block. It ties `rstn_i` to the synchronised button reset.

## Test plan
- Bytes 0x05, 0x03, 0x41, 0x0A → one `wr_en_o` pulse with col=5, row=3, din=0x41. `err_o` never asserts.
- Column byte 0xB4 (180), row 0x00, char 0x42, LF → write at col=5. Row byte 0x41 (65) → `err_o` pulse, no write.
- 0x01, 0x02, 0x43, 0x58 then 0x11, 0x0A:
  - 0x58 in place of LF → `err_o` pulse and entry to `S_SYNC`.
  - 0x11 is discarded; the 0x0A returns the decoder to `S_COL`.
  - The next valid packet writes normally.
- 0xFF, 0x0A → 11375 consecutive writes of 0x20. The first is at (0,0), the last at (174,64). `busy_o` is high for the same cycles. A byte injected mid-sweep gives `err_o` and leaves the sweep unaffected.
- Timeout recovery, with TIMEOUT_CYCLES overridden to 100:
  - Bytes 0x07, 0x02 then idle → `err_o` at the 100th idle cycle.
  - A following 0x01, 0x01, 0x44, 0x0A writes (1,1,0x44).
- `rstn_i` pulsed during a clear sweep and during `S_CHR` → all outputs 0 immediately. After release, a fresh packet decodes from column.
